// File: rtl/mem_request_sequencer.sv
// Request FIFO and single-outstanding command sequencer in front of the multicycle memory.
// Optional WAIT abort timer is compiled in with `define SEQ_TIMEOUT_EN.
module mem_request_sequencer #(
   parameter int DEPTH   = 4,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [1:0]        rsp_op,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              mem_start,
   output logic [1:0]        mem_op,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_done,
   input  logic [DATA_W-1:0] mem_rdata
);
   // state | meaning
   // IDLE  | waiting for a FIFO entry; pops the head into the command registers
   // ISSUE | mem_start pulse, command registers driven to the memory
   // WAIT  | command held until mem_done (or abort timer when enabled)
   // RESP  | response presented until rsp_ready

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
       TIMEOUT < 4 || TIMEOUT > 255) begin : g_bad_params
      $error("mem_request_sequencer: DEPTH must be a power of two in 2..16, TIMEOUT in 4..255");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   typedef struct packed {
      logic [1:0]        op;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   state_t            state_q, state_d;
   entry_t            fifo_q [DEPTH];
   entry_t            fifo_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              req_ready_q, req_ready_d;
   entry_t            cmd_q, cmd_d;
   logic [1:0]        rsp_op_q, rsp_op_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              push, pop;
   logic              tmo_hit;

   assign push = req_valid && req_ready_q;

   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         fifo_d[wr_ptr_q] = '{op: req_op, addr: req_addr, data: req_wdata};
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push && pop) begin
         count_d = count_q - CNT_W'(1);
      end
      req_ready_d = (count_d != CNT_W'(DEPTH));
   end

   always_comb begin
      state_d    = state_q;
      pop        = 1'b0;
      cmd_d      = cmd_q;
      rsp_op_d   = rsp_op_q;
      rsp_data_d = rsp_data_q;
      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               cmd_d   = fifo_q[rd_ptr_q];
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            // a completion in the same cycle as the abort still counts as a completion
            if (mem_done) begin
               rsp_op_d   = cmd_q.op;
               rsp_data_d = (cmd_q.op == 2'b01) ? mem_rdata : '0;
               state_d    = RESP;
            end else if (tmo_hit) begin
               rsp_op_d   = cmd_q.op;
               rsp_data_d = '0;
               state_d    = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         fifo_q      <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         req_ready_q <= 1'b0;
         cmd_q       <= '0;
         rsp_op_q    <= '0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         fifo_q      <= fifo_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         req_ready_q <= req_ready_d;
         cmd_q       <= cmd_d;
         rsp_op_q    <= rsp_op_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

`ifdef SEQ_TIMEOUT_EN
   logic [7:0] tmo_cnt_q, tmo_cnt_d;
   logic       rsp_err_q, rsp_err_d;

   // counter sits at zero on the first WAIT cycle, so the abort fires after TIMEOUT WAIT cycles
   assign tmo_hit = (state_q == WAIT) && (tmo_cnt_q == 8'(TIMEOUT - 1));

   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      rsp_err_d = rsp_err_q;
      if (state_q == ISSUE) begin
         tmo_cnt_d = '0;
      end else if (state_q == WAIT) begin
         tmo_cnt_d = tmo_cnt_q + 8'd1;
         if (mem_done) begin
            rsp_err_d = 1'b0;
         end else if (tmo_hit) begin
            rsp_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_q <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   assign rsp_err = rsp_err_q;
`else
   assign tmo_hit = 1'b0;
   assign rsp_err = 1'b0;
`endif

   assign req_ready = req_ready_q;
   assign mem_start = (state_q == ISSUE);
   assign mem_op    = cmd_q.op;
   assign mem_addr  = cmd_q.addr;
   assign mem_wdata = cmd_q.data;
   assign rsp_valid = (state_q == RESP);
   assign rsp_op    = rsp_op_q;
   assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mem_request_sequencer.sv
// Bench for mem_request_sequencer: memory device model, request/response scoreboard with a
// cycle-level timing model, directed scenarios and a randomized traffic phase.
module tb_mem_request_sequencer;
   localparam int DEPTH = 4;
   localparam int TO    = 6;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0, rsp_ready = 1'b0;
   logic [1:0] req_op = '0;
   logic [7:0] req_addr = '0, req_wdata = '0;
   logic       req_ready, rsp_valid, rsp_err, mem_start;
   logic [1:0] rsp_op, mem_op;
   logic [7:0] rsp_data, mem_addr, mem_wdata;
   logic       mem_done = 1'b0;
   logic [7:0] mem_rdata = '0;

   always #5 clk = ~clk;

   mem_request_sequencer #(.DEPTH(DEPTH), .ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .mem_start(mem_start), .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_done(mem_done), .mem_rdata(mem_rdata)
   );

   typedef struct packed { logic [1:0] op; logic [7:0] addr; logic [7:0] wdata; logic drop; int pcyc; } req_t;
   typedef struct packed { logic [1:0] op; logic [7:0] data; logic err; } rsp_t;

   int n_cmp = 0, n_bad = 0;
   int cyc = 0;
   logic [7:0] dev_mem [256];
   logic [7:0] ref_mem [256];
   req_t iss_q[$];
   rsp_t exp_q[$];
   rsp_t log_q[$];
   bit   pending_mem = 0, outstanding = 0, drop_next = 0;
   int   spur_en = 0;
   int   done_cycle = -1, tmo_cycle = -1, last_hs = 0, occ = 0, start_cnt = 0;
   req_t cmd;
   logic prev_valid = 0, prev_ready = 0, prev_err = 0;
   logic [1:0] prev_op = '0;
   logic [7:0] prev_data = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // memory device: done at start+4 for read/write, start+3 for no-op
   always @(posedge clk) begin
      if (!rst_n) begin
         cyc = 0;
      end else begin
         cyc = cyc + 1;
         #1;
         mem_done  = 1'b0;
         mem_rdata = 8'($urandom);
         if (pending_mem && cyc == done_cycle) begin
            mem_done = 1'b1;
            if (cmd.op == 2'b01) mem_rdata = dev_mem[cmd.addr];
         end else if (!pending_mem && (spur_en == 2 || (spur_en == 1 && $urandom_range(0, 3) == 0))) begin
            mem_done = 1'b1;
         end
      end
   end

   // scoreboard and timing model, sampled mid-cycle
   always @(negedge clk) begin
      if (rst_n && cyc > 0) begin
         int   base;
         bit   model_start;
         req_t h;
         rsp_t e;
         chk("rsp_valid", rsp_valid, outstanding && !pending_mem);
         if (rsp_valid) begin
            if (prev_valid && !prev_ready) begin
               chk("rsp_hold_op", rsp_op, prev_op);
               chk("rsp_hold_data", rsp_data, prev_data);
               chk("rsp_hold_err", rsp_err, prev_err);
            end
            if (rsp_ready) begin
               chk("rsp_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("rsp_op", rsp_op, e.op);
                  chk("rsp_data", rsp_data, e.data);
                  chk("rsp_err", rsp_err, e.err);
               end
               log_q.push_back('{op: rsp_op, data: rsp_data, err: rsp_err});
               outstanding = 0;
               last_hs = cyc;
            end
         end

         model_start = 0;
         if (iss_q.size() != 0 && !outstanding) begin
            base = (iss_q[0].pcyc > last_hs) ? iss_q[0].pcyc : last_hs;
            model_start = (cyc >= base + 2);
         end
         chk("mem_start", mem_start, model_start);
         if (mem_start && iss_q.size() != 0) begin
            h = iss_q.pop_front();
            start_cnt++;
            chk("start_op", mem_op, h.op);
            chk("start_addr", mem_addr, h.addr);
            chk("start_wdata", mem_wdata, h.wdata);
            cmd = h;
            pending_mem = 1;
            outstanding = 1;
            occ--;
            if (h.drop) begin
               done_cycle = -1;
               tmo_cycle  = cyc + TO;
            end else begin
               done_cycle = cyc + (h.op[1] ? 3 : 4);
               tmo_cycle  = -1;
            end
         end else if (pending_mem) begin
            chk("hold_op", mem_op, cmd.op);
            chk("hold_addr", mem_addr, cmd.addr);
            chk("hold_wdata", mem_wdata, cmd.wdata);
            if (cyc == done_cycle || cyc == tmo_cycle) begin
               if (cyc == done_cycle && cmd.op == 2'b00) dev_mem[cmd.addr] = cmd.wdata;
               pending_mem = 0;
            end
         end

         chk("req_ready", req_ready, occ != DEPTH);
         if (req_valid && req_ready) begin
            iss_q.push_back('{op: req_op, addr: req_addr, wdata: req_wdata, drop: drop_next, pcyc: cyc});
            if (drop_next)            exp_q.push_back('{op: req_op, data: 8'h00, err: 1'b1});
            else if (req_op == 2'b00) begin
               ref_mem[req_addr] = req_wdata;
               exp_q.push_back('{op: req_op, data: 8'h00, err: 1'b0});
            end
            else if (req_op == 2'b01) exp_q.push_back('{op: req_op, data: ref_mem[req_addr], err: 1'b0});
            else                      exp_q.push_back('{op: req_op, data: 8'h00, err: 1'b0});
            occ++;
         end

         prev_valid = rsp_valid; prev_ready = rsp_ready;
         prev_op = rsp_op; prev_data = rsp_data; prev_err = rsp_err;
      end
   end

   task automatic push(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
      int n = 0;
      req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d;
      while (!req_ready && n < 500) begin
         @(posedge clk); #1; n++;
      end
      chk("push_accept", req_ready, 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_log(input int n);
      int k = 0;
      while (log_q.size() < n && k < 3000) begin
         @(posedge clk); #1; k++;
      end
      chk("wait_rsp", log_q.size() >= n, 1);
   endtask

   task automatic wait_valid();
      int k = 0;
      while (!rsp_valid && k < 500) begin
         @(posedge clk); #1; k++;
      end
      chk("wait_rsp_valid", rsp_valid, 1);
   endtask

   initial begin
      int b, sc;
      for (int i = 0; i < 256; i++) begin dev_mem[i] = 8'h00; ref_mem[i] = 8'h00; end
      #2;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_mem_start", mem_start, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_mem_cmd", {mem_op, mem_addr, mem_wdata}, 0);
      chk("rst_rsp", {rsp_op, rsp_data, rsp_err}, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      repeat (5) begin @(posedge clk); #1; end
      chk("idle_req_ready", req_ready, 1);
      chk("idle_no_start", start_cnt, 0);

      // write then read
      rsp_ready = 1'b1;
      push(2'b00, 8'h3C, 8'hA5);
      push(2'b01, 8'h3C, 8'h00);
      wait_log(2);
      chk("wr_rsp_op", log_q[0].op, 2'b00);
      chk("wr_rsp_data", log_q[0].data, 8'h00);
      chk("rd_rsp_op", log_q[1].op, 2'b01);
      chk("rd_rsp_data", log_q[1].data, 8'hA5);
      chk("two_starts", start_cnt, 2);

      // fill and drain
      rsp_ready = 1'b0;
      b = log_q.size();
      for (int i = 0; i < 5; i++) push(2'b00, 8'(i), 8'(8'h50 + i));
      chk("fill_ready_low", req_ready, 0);
      rsp_ready = 1'b1;
      wait_log(b + 5);
      for (int i = 0; i < 5; i++) push(2'b01, 8'(i), 8'h00);
      wait_log(b + 10);
      for (int i = 0; i < 5; i++) chk("fill_readback", log_q[b + 5 + i].data, 8'(8'h50 + i));

      // no-op leaves memory alone
      b = log_q.size();
      push(2'b10, 8'h3C, 8'h77);
      push(2'b01, 8'h3C, 8'h00);
      wait_log(b + 2);
      chk("noop_op", log_q[b].op, 2'b10);
      chk("noop_data", log_q[b].data, 8'h00);
      chk("noop_mem_kept", log_q[b + 1].data, 8'hA5);

      // response backpressure
      rsp_ready = 1'b0;
      b = log_q.size();
      push(2'b01, 8'h02, 8'h00);
      wait_valid();
      sc = start_cnt;
      push(2'b01, 8'h03, 8'h00);
      repeat (10) begin @(posedge clk); #1; end
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 8'h52);
      chk("bp_no_start", start_cnt, sc);
      rsp_ready = 1'b1;
      wait_log(b + 2);
      chk("bp_second", log_q[b + 1].data, 8'h53);

`ifdef SEQ_TIMEOUT_EN
      rsp_ready = 1'b0;
      b = log_q.size();
      drop_next = 1;
      push(2'b01, 8'h01, 8'h00);
      drop_next = 0;
      wait_valid();
      chk("tmo_err", rsp_err, 1);
      chk("tmo_data", rsp_data, 8'h00);
      spur_en = 2;
      repeat (4) begin @(posedge clk); #1; end
      spur_en = 0;
      rsp_ready = 1'b1;
      push(2'b01, 8'h01, 8'h00);
      wait_log(b + 2);
      chk("tmo_first_err", log_q[b].err, 1);
      chk("tmo_next_err", log_q[b + 1].err, 0);
      chk("tmo_next_data", log_q[b + 1].data, 8'h51);
`endif

      // randomized traffic with spurious done outside WAIT
      spur_en = 1;
      for (int i = 0; i < 600; i++) begin
         req_valid = ($urandom_range(0, 2) == 0);
         req_op    = 2'($urandom);
         req_addr  = 8'($urandom_range(0, 7));
         req_wdata = 8'($urandom);
         if ((i / 60) % 3 == 2) rsp_ready = ($urandom_range(0, 7) == 0);
         else                   rsp_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      begin
         int k = 0;
         while ((iss_q.size() != 0 || outstanding) && k < 3000) begin
            @(posedge clk); #1; k++;
         end
      end
      spur_en = 0;
      repeat (3) begin @(posedge clk); #1; end
      chk("final_drain", iss_q.size() + exp_q.size() + 32'(outstanding), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
